// File: rtl/bus_copy_master_if.sv
// bus_copy_master_if: arbitration handshake plus address/write-enable side of the shared bus.
interface bus_copy_master_if #(
    parameter int ADDR_WIDTH = 8
);
    logic req;
    logic gnt;
    logic we;
    logic [ADDR_WIDTH-1:0] addr;
    modport master (output req, addr, we, input gnt);
    modport slave (input req, addr, we, output gnt);
endinterface

// File: rtl/bus_copy_master.sv
// bus_copy_master: bus-master DMA copying length bytes from src_addr to dst_addr, one byte per 4 cycles.
module bus_copy_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [7:0]            length,
    output logic                  busy,
    output logic                  done,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    bus_copy_master_if.master     bus
);
    typedef enum logic [2:0] {IDLE, REQ, RD0, RD1, TURN, WR, FIN} state_t;
    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] src, src_n, dst, dst_n, addr_n;
    logic [7:0] len, len_n, idx, idx_n;
    logic [DATA_WIDTH-1:0] rd_data;
    logic drive, own_n, we_n;
    assign bus_data = drive ? rd_data : 'z;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            src <= '0;
            dst <= '0;
            len <= '0;
            idx <= '0;
            rd_data <= '0;
            drive <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            bus.req <= 1'b0;
            bus.we <= 1'b0;
            bus.addr <= '0;
        end else begin
            state <= state_n;
            src <= src_n;
            dst <= dst_n;
            len <= len_n;
            idx <= idx_n;
            rd_data <= state == RD1 ? bus_data : rd_data;
            drive <= state_n == WR;
            busy <= own_n;
            done <= state_n == FIN;
            bus.req <= own_n;
            bus.we <= we_n;
            bus.addr <= addr_n;
        end
    end
    always_comb begin
        state_n = state;
        src_n = src;
        dst_n = dst;
        len_n = len;
        idx_n = idx;
        case (state)
            IDLE: if (start) begin
                src_n = src_addr;
                dst_n = dst_addr;
                len_n = length;
                idx_n = '0;
                state_n = length == 8'd0 ? FIN : REQ;
            end
            REQ: state_n = bus.gnt ? RD0 : REQ;
            RD0: state_n = RD1;
            RD1: state_n = TURN;
            TURN: state_n = WR;
            WR: begin
                idx_n = idx + 8'd1;
                state_n = idx + 8'd1 == len ? FIN : RD0;
            end
            default: state_n = IDLE;
        endcase
    end
    // Outputs are decoded from the next state so they leave the flops aligned with the state.
    always_comb begin
        own_n = state_n inside {REQ, RD0, RD1, TURN, WR};
        we_n = state_n inside {TURN, WR};
        addr_n = state_n == WR ? dst_n + ADDR_WIDTH'(idx_n)
               : state_n inside {RD0, RD1, TURN} ? src_n + ADDR_WIDTH'(idx_n) : '0;
    end
endmodule
